// File: rtl/uart_mem_pkg.sv
// Shared states and protocol constants for the
// UART command controller and its memory.
package uart_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    SEND,
    WAIT_TX
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] ACK      = 8'hA5;
  localparam logic [7:0] NAK      = 8'h5A;

endpackage

// File: rtl/uart_mem_ram.sv
// Single-port RAM, synchronous write and
// one-cycle synchronous read, no reset.
module uart_mem_ram #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [AW-1:0] wdata_i,
  output logic [AW-1:0] rdata_o
);

  logic [AW-1:0] mem_q [2**AW];
  logic [AW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_mem_ctrl.sv
// Parses UART words into memory write/read
// commands and answers through the transmitter.
module uart_mem_ctrl
  import uart_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  output logic                  clr_rx_done,
  output logic [ADDR_WIDTH-1:0] tx_data,
  output logic                  trmt,
  input  logic                  tx_done,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

  localparam int AW = ADDR_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [AW-1:0] OPW   = AW'(OP_WRITE);
  localparam logic [AW-1:0] OPR   = AW'(OP_READ);
  localparam logic [AW-1:0] ACK_W = AW'(ACK);
  localparam logic [AW-1:0] NAK_W = AW'(NAK);

  state_t        state_q, state_d;
  logic [AW-1:0] op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] data_q, data_d;
  logic [AW-1:0] txd_q, txd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    err_q, err_d;
  logic [AW-1:0] rdata;
  logic          cap, we, re, err_inc;

  uart_mem_ram #(.AW(AW)) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .re_i    (re),
    .addr_i  (addr_q),
    .wdata_i (data_q),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    txd_d   = txd_q;
    tmo_d   = tmo_q;
    cap     = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    err_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_done) begin
          cap  = 1'b1;
          op_d = rx_data;
          if (rx_data == OPW || rx_data == OPR) begin
            state_d = GET_ADDR;
          end else begin
            err_inc = 1'b1;
            txd_d   = NAK_W;
            state_d = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rx_done) begin
          cap     = 1'b1;
          addr_d  = rx_data;
          state_d = (op_q == OPW) ? GET_DATA : READ;
        end else if (tmo_q == TMO_MAX) begin
          err_inc = 1'b1;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GET_DATA: begin
        if (rx_done) begin
          cap     = 1'b1;
          data_d  = rx_data;
          state_d = WRITE;
        end else if (tmo_q == TMO_MAX) begin
          err_inc = 1'b1;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WRITE: begin
        we      = 1'b1;
        txd_d   = ACK_W;
        state_d = SEND;
      end
      READ: begin
        re      = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (op_q == OPR) txd_d = rdata;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cap) tmo_d = '0;
    err_d = err_q;
    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      txd_q   <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      txd_q   <= txd_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Read data only exists once SEND is entered, so it
  // bypasses the register there and is latched for WAIT_TX.
  assign tx_data = (state_q == SEND && op_q == OPR)
                   ? rdata : txd_q;
  assign clr_rx_done = cap;
  assign trmt        = (state_q == SEND);
  assign busy        = (state_q != IDLE);
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Scoreboard bench for uart_mem_ctrl with simple
// receiver and transmitter handshake models.
module tb_uart_mem_ctrl;

  localparam int AW  = 8;
  localparam int TMO = 50;
  localparam int TXD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rx_data = '0;
  logic          rx_done = 1'b0;
  logic          clr_rx_done;
  logic [AW-1:0] tx_data;
  logic          trmt;
  logic          tx_done = 1'b1;
  logic          busy;
  logic [7:0]    err_cnt;

  int tests = 0;
  int fails = 0;
  int n_clr = 0;
  int n_trmt = 0;
  int tx_cnt = 0;
  int exp_err = 0;

  logic [AW-1:0] rxq  [$];
  logic [AW-1:0] expq [$];

  uart_mem_ctrl #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .clr_rx_done (clr_rx_done),
    .tx_data     (tx_data),
    .trmt        (trmt),
    .tx_done     (tx_done),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Receiver: presents queued words, drops rx_done on clear.
  always @(posedge clk) begin
    if (clr_rx_done) begin
      n_clr++;
      rx_done <= 1'b0;
    end else if (!rx_done && rxq.size() != 0) begin
      rx_data <= rxq.pop_front();
      rx_done <= 1'b1;
    end
  end

  // Transmitter: busy for TXD cycles after each trmt.
  always @(posedge clk) begin
    if (trmt) begin
      n_trmt++;
      tx_done <= 1'b0;
      tx_cnt  <= TXD;
    end else if (!tx_done) begin
      if (tx_cnt == 0) tx_done <= 1'b1;
      else tx_cnt <= tx_cnt - 1;
    end
  end

  task automatic send_wr(input logic [AW-1:0] a,
                         input logic [AW-1:0] d);
    rxq.push_back(8'h01);
    rxq.push_back(a);
    rxq.push_back(d);
    expq.push_back(8'hA5);
  endtask

  task automatic send_rd(input logic [AW-1:0] a,
                         input logic [AW-1:0] d);
    rxq.push_back(8'h02);
    rxq.push_back(a);
    expq.push_back(d);
  endtask

  task automatic wait_rx_idle(input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      if (rxq.size() == 0 && !rx_done) break;
      @(negedge clk);
    end
    if (i == 200) begin
      tests++;
      fails++;
      $display("FAIL %s: rx words never consumed", nm);
    end
  endtask

  task automatic wait_trmt(input string nm,
                           output bit clr_seen);
    logic [AW-1:0] exp;
    bit            bad_hold;
    int            i;
    clr_seen = 1'b0;
    bad_hold = 1'b0;
    for (i = 0; i < 200 && !trmt; i++) @(negedge clk);
    tests++;
    if (!trmt) begin
      fails++;
      $display("FAIL %s: no trmt within budget", nm);
      return;
    end
    exp = (expq.size() != 0) ? expq.pop_front() : 'x;
    if (tx_data !== exp) begin
      fails++;
      $display("FAIL %s data: got %h want %h",
               nm, tx_data, exp);
    end
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_data !== exp) bad_hold = 1'b1;
      if (clr_rx_done) clr_seen = 1'b1;
      if (tx_done) break;
    end
    tests++;
    if (bad_hold || !tx_done) begin
      fails++;
      $display("FAIL %s hold: tx_data %h want %h done %b",
               nm, tx_data, exp, tx_done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({trmt, clr_rx_done, busy} !== 3'b000 ||
        tx_data !== 8'h00 || err_cnt !== 8'h00) begin
      fails++;
      $display("FAIL reset: trmt%b clr%b busy%b tx%h err%h",
               trmt, clr_rx_done, busy, tx_data, err_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    bit c;
    int i;
    send_wr(8'h3C, 8'hE7);
    wait_trmt("wr_ack", c);
    send_rd(8'h3C, 8'hE7);
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (clr_rx_done && busy) break;
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (trmt !== 1'b1) begin
      fails++;
      $display("FAIL rd_latency: trmt %b want 1", trmt);
    end
    wait_trmt("rd_data", c);
    tests++;
    if (err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL wr_rd_err: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_bad_opcode();
    bit c;
    int c0, i;
    c0 = n_clr;
    rxq.push_back(8'h77);
    expq.push_back(8'h5A);
    exp_err++;
    for (i = 0; i < 100 && !clr_rx_done; i++) @(negedge clk);
    @(negedge clk);
    tests++;
    if (trmt !== 1'b1) begin
      fails++;
      $display("FAIL nak_latency: trmt %b want 1", trmt);
    end
    wait_trmt("nak", c);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL nak_busy: got %b want 0", busy);
    end
    tests++;
    if (n_clr - c0 != 1) begin
      fails++;
      $display("FAIL nak_clr: got %0d pulses want 1", n_clr - c0);
    end
    tests++;
    if (err_cnt !== 8'(exp_err)) begin
      fails++;
      $display("FAIL nak_err: got %0d want %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_timeout();
    bit c;
    int t0;
    send_wr(8'h10, 8'h55);
    wait_trmt("tmo_pre", c);
    @(negedge clk);
    rxq.push_back(8'h01);
    rxq.push_back(8'h10);
    wait_rx_idle("tmo_cmd");
    t0 = n_trmt;
    repeat (40) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL tmo_early: busy %b want 1", busy);
    end
    repeat (20) @(negedge clk);
    exp_err++;
    tests++;
    if (busy !== 1'b0 || err_cnt !== 8'(exp_err)) begin
      fails++;
      $display("FAIL tmo_abort: busy %b err %0d want 0 %0d",
               busy, err_cnt, exp_err);
    end
    tests++;
    if (n_trmt != t0) begin
      fails++;
      $display("FAIL tmo_trmt: got %0d want 0", n_trmt - t0);
    end
    send_rd(8'h10, 8'h55);
    wait_trmt("tmo_read", c);
  endtask

  task automatic test_back_to_back();
    bit c;
    send_wr(8'h40, 8'h99);
    send_rd(8'h40, 8'h99);
    wait_trmt("b2b_wr", c);
    tests++;
    if (c || rx_done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_pending: clr %b rx_done %b want 0 1",
               c, rx_done);
    end
    wait_trmt("b2b_rd", c);
  endtask

  task automatic test_err_sat();
    bit c;
    for (int k = 0; k < 300; k++) begin
      rxq.push_back(8'h80 + 8'(k % 64));
      expq.push_back(8'h5A);
      if (exp_err < 255) exp_err++;
      wait_trmt("sat_nak", c);
    end
    @(negedge clk);
    tests++;
    if (err_cnt !== 8'd255 || exp_err != 255) begin
      fails++;
      $display("FAIL err_sat: got %0d want 255", err_cnt);
    end
  endtask

  task automatic test_reset_mid_write();
    bit c;
    send_wr(8'h20, 8'h11);
    wait_trmt("rst_pre", c);
    @(negedge clk);
    rxq.push_back(8'h01);
    rxq.push_back(8'h20);
    wait_rx_idle("rst_cmd");
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_setup: busy %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({trmt, clr_rx_done, busy} !== 3'b000 ||
        tx_data !== 8'h00 || err_cnt !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid: trmt%b clr%b busy%b tx%h err%h",
               trmt, clr_rx_done, busy, tx_data, err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_rd(8'h20, 8'h11);
    wait_trmt("rst_read", c);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bad_opcode();
    test_timeout();
    test_back_to_back();
    test_err_sat();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
